timer_cnt_core: RTL
===================

// Module: timer_cnt_core
// PURPOSE
//  Timer counter stage fed by the clock-select block (clk2/4/8/16 chosen by cks).
//  - Detects rising edges of the selected divided clock in the pclk domain.
//  - Counts up or down, and reloads from the timer data register.
//  - Raises overflow/underflow pulses and sticky flags for the interrupt handler.
// PARAMETERS
//  CNT_W     8    counter / load-data width in bits
// PORTS
//  pclk      in   1      system clock; all state on rising edge
//  preset_n  in   1      asynchronous active-low reset
//  clk_in    in   1      selected divided clock from clk select (pclk-synchronous)
//  cnt_en    in   1      1 = count on clk_in rising edges
//  up_down   in   1      0 = count up, 1 = count down
//  load      in   1      1-pclk pulse: cnt <= tdr
//  tdr       in   CNT_W  reload value
//  clr_ovf   in   1      1-pclk pulse: clear s_ovf
//  clr_udf   in   1      1-pclk pulse: clear s_udf
//  cnt       out  CNT_W  current count
//  ovf_pulse out  1      1-pclk pulse on up-count wrap from all-ones to 0
//  udf_pulse out  1      1-pclk pulse on down-count wrap from 0 to all-ones
//  s_ovf     out  1      sticky overflow flag
//  s_udf     out  1      sticky underflow flag
// BEHAVIOUR
//  - Reset: cnt, ovf_pulse, udf_pulse, s_ovf, s_udf and clk_in_d all 0, applied immediately.
//  - Reset mid-count abandons the count. Counting resumes only after preset_n deasserts.
//  - clk_in_d is clk_in registered on pclk.
//  - tick = clk_in & ~clk_in_d, giving exactly one tick per clk_in period.
//  - Count update happens on the pclk edge that first samples clk_in high after it was low.
//  - Priority at each pclk edge: load > tick&cnt_en > hold.
//  - Load: cnt <= tdr on the next edge. A tick in the same cycle is dropped. No flags change.
//  - Up count: cnt <= cnt+1 modulo 2^CNT_W.
//    On all-ones -> 0: ovf_pulse=1 for that one cycle; s_ovf set.
//  - Down count: cnt <= cnt-1 modulo 2^CNT_W.
//    On 0 -> all-ones: udf_pulse=1 for that one cycle; s_udf set.
//  - ovf_pulse and udf_pulse are 0 in every cycle without a wrap.
//  - Sticky flags: a set and a clear in the same cycle leave the flag at 1 (set wins).
//    A clear with no set gives 0 on the next edge.
//  - cnt_en=0: cnt holds and edge detection keeps running.
//    Re-enabling does not generate a spurious tick.
//  - up_down change: applies from the next tick. No pulse is generated by the change itself.
//  - Loading all-ones while counting up does not overflow until the following tick.
// CONFIGURATION
//  TMR_CMP_EN defined:
//    - Adds ports tcmp in CNT_W, clr_cmp in 1 and s_cmp out 1.
//    - s_cmp is set on the edge where the counted (not loaded) cnt becomes equal to tcmp.
//    - s_cmp reset value 0. Set-vs-clear: set wins.
//  TMR_CMP_EN undefined:
//    - Ports tcmp, clr_cmp and s_cmp are absent.
//    - No compare logic is present.
// TESTING  (pclk period 20ns, clk_in = clk2 with 40ns period)
//  1. Reset:
//     preset_n=0 mid-count, with cnt=0x5A -> cnt=0 and all flags/pulses 0 immediately.
//  2. Up wrap:
//     load tdr=0xFD, up_down=0, cnt_en=1 -> cnt FE,FF,00 on successive ticks.
//     ovf_pulse high for 1 pclk at 00; s_ovf=1.
//  3. Down wrap:
//     load tdr=0x01, up_down=1 -> cnt 00 then FF.
//     udf_pulse high for 1 pclk; s_udf=1; s_ovf unchanged.
//  4. Hold:
//     cnt=0x10, cnt_en=0 for 10 clk_in periods -> cnt stays 0x10.
//     Re-enable -> 0x11 on the next tick only.
//  5. Collisions:
//     load tdr=0x80 on a tick cycle -> cnt=0x80, no increment.
//     clr_ovf on a wrap cycle -> s_ovf=1.
//     clr_ovf alone -> s_ovf=0.
//  6. TMR_CMP_EN:
//     tcmp=0x05, count up from 0x03 -> s_cmp=1 when cnt=0x05.
//     clr_cmp -> s_cmp=0.
//     Load of tdr=0x05 -> s_cmp stays 0.

Source files
------------

// File: rtl/timer_cnt_core.sv
// Timer counter stage: edge-detects the selected divided clock, counts up/down with reload,
// and reports wraps as pulses plus sticky flags. Optional compare flag under TMR_CMP_EN.

module timer_cnt_core_chk (
   input logic pclk,
   input logic preset_n,
   input logic ovf_pulse,
   input logic udf_pulse,
   input logic s_ovf,
   input logic s_udf
);

   // A single count step can wrap in only one direction
   ap_one_wrap : assert property (@(posedge pclk) disable iff (!preset_n)
      !(ovf_pulse && udf_pulse));

   // Sticky flags are set on the same edge that raises the wrap pulse
   ap_ovf_sticky : assert property (@(posedge pclk) disable iff (!preset_n)
      ovf_pulse |-> s_ovf);

   ap_udf_sticky : assert property (@(posedge pclk) disable iff (!preset_n)
      udf_pulse |-> s_udf);

endmodule

module timer_cnt_core #(
   parameter int CNT_W = 8
) (
   input  logic             pclk,
   input  logic             preset_n,
   input  logic             clk_in,
   input  logic             cnt_en,
   input  logic             up_down,
   input  logic             load,
   input  logic [CNT_W-1:0] tdr,
   input  logic             clr_ovf,
   input  logic             clr_udf,
`ifdef TMR_CMP_EN
   input  logic [CNT_W-1:0] tcmp,
   input  logic             clr_cmp,
   output logic             s_cmp,
`endif
   output logic [CNT_W-1:0] cnt,
   output logic             ovf_pulse,
   output logic             udf_pulse,
   output logic             s_ovf,
   output logic             s_udf
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             clk_in_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_pulse_q, ovf_pulse_d;
   logic             udf_pulse_q, udf_pulse_d;
   logic             s_ovf_q, s_ovf_d;
   logic             s_udf_q, s_udf_d;
   logic             tick;
   logic             count_step;

   // Next count, wrap detection and sticky flag update (load beats a same-cycle tick)
   always_comb begin
      tick        = clk_in & ~clk_in_q;
      count_step  = ~load & tick & cnt_en;
      cnt_d       = cnt_q;
      ovf_pulse_d = 1'b0;
      udf_pulse_d = 1'b0;
      if (load) begin
         cnt_d = tdr;
      end else if (count_step) begin
         if (up_down) begin
            cnt_d       = cnt_q - CNT_ONE;
            udf_pulse_d = (cnt_q == CNT_ZERO);
         end else begin
            cnt_d       = cnt_q + CNT_ONE;
            ovf_pulse_d = (cnt_q == CNT_MAX);
         end
      end else begin
         cnt_d = cnt_q;
      end
      s_ovf_d = ovf_pulse_d | (s_ovf_q & ~clr_ovf);
      s_udf_d = udf_pulse_d | (s_udf_q & ~clr_udf);
   end

   // Counter, edge-detect and flag registers
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         clk_in_q    <= 1'b0;
         cnt_q       <= CNT_ZERO;
         ovf_pulse_q <= 1'b0;
         udf_pulse_q <= 1'b0;
         s_ovf_q     <= 1'b0;
         s_udf_q     <= 1'b0;
      end else begin
         clk_in_q    <= clk_in;
         cnt_q       <= cnt_d;
         ovf_pulse_q <= ovf_pulse_d;
         udf_pulse_q <= udf_pulse_d;
         s_ovf_q     <= s_ovf_d;
         s_udf_q     <= s_udf_d;
      end
   end

`ifdef TMR_CMP_EN
   logic s_cmp_q, s_cmp_d;

   // Compare only fires on a counted value, never on a reload
   always_comb begin
      s_cmp_d = (count_step & (cnt_d == tcmp)) | (s_cmp_q & ~clr_cmp);
   end

   // Compare flag register
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         s_cmp_q <= 1'b0;
      end else begin
         s_cmp_q <= s_cmp_d;
      end
   end

   assign s_cmp = s_cmp_q;
`endif

   assign cnt       = cnt_q;
   assign ovf_pulse = ovf_pulse_q;
   assign udf_pulse = udf_pulse_q;
   assign s_ovf     = s_ovf_q;
   assign s_udf     = s_udf_q;

   timer_cnt_core_chk u_chk (
      .pclk      (pclk),
      .preset_n  (preset_n),
      .ovf_pulse (ovf_pulse_q),
      .udf_pulse (udf_pulse_q),
      .s_ovf     (s_ovf_q),
      .s_udf     (s_udf_q)
   );

endmodule
